cycle_arbiter: RTL and testbench

CYCLE_ARBITER -- requirements
Module: cycle_arbiter

---
 rtl/cycle_arbiter.sv | 142 ++++++++++++++
 tb/tb_cycle_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cycle_arbiter.sv
// cycle_arbiter: two-requester round-robin owner of a START/RUN/STOP/CLEAR
// process cycle. All outputs are flops loaded from the next-state decode, so
// they track the current state with no input-to-output combinational path.
module cycle_arbiter #(
  parameter int CNT_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [1:0]       req,
  input  logic [CNT_W-1:0] run_len,
  input  logic             abort,
  output logic [1:0]       grant,
  output logic             K1,
  output logic             K2,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_START = 3'b001,
    S_RUN   = 3'b010,
    S_STOP  = 3'b011,
    S_CLEAR = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] len_q,   len_d;
  logic             last_q,  last_d;
  logic             k1_q,    k1_d;
  logic             k2_q,    k2_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             arb_idx;

  // Round-robin pick: on contention the requester that did not win last time.
  always_comb begin
    arb_idx = last_q;
    case (req)
      2'b01:   arb_idx = 1'b0;
      2'b10:   arb_idx = 1'b1;
      2'b11:   arb_idx = ~last_q;
      default: arb_idx = last_q;
    endcase
  end

  // Next-state, owner, run length and counter.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        grant_d = 2'b00;
        if (req != 2'b00) begin
          state_d = S_START;
          grant_d = arb_idx ? 2'b10 : 2'b01;
          last_d  = arb_idx;
          // A zero length still runs for one cycle.
          len_d   = (run_len == '0) ? ONE : run_len;
        end
      end
      S_START: begin
        if (abort) begin
          state_d = S_STOP;
        end else begin
          state_d = S_RUN;
          cnt_d   = len_q - ONE;
        end
      end
      S_RUN: begin
        // Counter counts L-1 down to 0, so RUN spans exactly L cycles and
        // never needs to hold the value L itself (no wrap at all-ones).
        if (abort || cnt_q == '0) begin
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_STOP: begin
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Output decode from the next state so the registered strobes line up
  // with the state they belong to.
  always_comb begin
    k1_d   = (state_d == S_START);
    k2_d   = (state_d == S_STOP);
    done_d = (state_d == S_CLEAR);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any cycle in flight.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      cnt_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b1;
      k1_q    <= 1'b0;
      k2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      last_q  <= last_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign grant = grant_q;
  assign K1    = k1_q;
  assign K2    = k2_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_cycle_arbiter.sv
// Bench for cycle_arbiter: a queue-based schedule model predicts the state
// sequence of each granted cycle; directed scenarios add literal checks.
module tb_cycle_arbiter;
  localparam int CNT_W = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_RUN = 3'd2,
                         S_STOP = 3'd3, S_CLEAR = 3'd4;

  logic             Clock = 1'b0;
  logic             Reset;
  logic [1:0]       req;
  logic [CNT_W-1:0] run_len;
  logic             abort;
  logic [1:0]       grant;
  logic             K1, K2, busy, done;
  logic [2:0]       state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, run_cnt = 0, last_run = 0;
  int k1_t = 0, prev_k1_t = 0, k2_t = 0, k2_n = 0, done_n = 0;
  logic [1:0] g_start = 2'b00;

  cycle_arbiter #(.CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .req(req), .run_len(run_len), .abort(abort),
    .grant(grant), .K1(K1), .K2(K2), .busy(busy), .done(done), .state(state)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: on grant, the whole expected state schedule is queued up front.
  logic [2:0] m_state = S_IDLE;
  logic [1:0] m_grant = 2'b00;
  bit         m_last  = 1'b1;
  logic [2:0] sched[$];

  initial begin
    bit idx;
    int len;
    forever begin
      @(posedge Clock or negedge Reset);
      if (!Reset) begin
        m_state = S_IDLE; m_grant = 2'b00; m_last = 1'b1; sched.delete();
      end else begin
        if (m_state == S_IDLE && req != 2'b00) begin
          if (req == 2'b11) idx = ~m_last;
          else              idx = req[1];
          m_last  = idx;
          m_grant = idx ? 2'b10 : 2'b01;
          len = (run_len == '0) ? 1 : int'(run_len);
          sched.push_back(S_START);
          repeat (len) sched.push_back(S_RUN);
          sched.push_back(S_STOP);
          sched.push_back(S_CLEAR);
        end else if ((m_state == S_START || m_state == S_RUN) && abort) begin
          sched.delete();
          sched.push_back(S_STOP);
          sched.push_back(S_CLEAR);
        end
        if (sched.size() > 0) m_state = sched.pop_front();
        else begin m_state = S_IDLE; m_grant = 2'b00; end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge Clock) begin
    check("outputs", {23'd0, state, grant, K1, K2, busy, done},
          {23'd0, m_state, (m_state == S_IDLE) ? 2'b00 : m_grant,
           m_state == S_START, m_state == S_STOP, m_state != S_IDLE, m_state == S_CLEAR});
  end

  // Event monitor used by the directed checks.
  always @(negedge Clock) begin
    cyc++;
    if (!Reset) run_cnt = 0;
    else begin
      if (state == S_RUN) run_cnt++;
      if (K1) begin prev_k1_t = k1_t; k1_t = cyc; g_start = grant; end
      if (K2) begin k2_t = cyc; k2_n++; end
      if (done) begin last_run = run_cnt; run_cnt = 0; done_n++; end
    end
  end

  // which: 0=K1 1=K2 2=done 3=RUN 4=IDLE
  task automatic wait_ev(input int which, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge Clock); #1;
      case (which)
        0:       hit = K1;
        1:       hit = K2;
        2:       hit = done;
        3:       hit = (state == S_RUN);
        default: hit = (state == S_IDLE);
      endcase
    end
    check(name, {31'd0, hit}, 32'd1);
  endtask

  initial begin
    int k2_save, done_save;
    Reset = 1'b0; req = 2'b00; run_len = '0; abort = 1'b0;
    repeat (3) @(posedge Clock);
    #2;
    check("reset_state", state, S_IDLE);
    check("reset_grant", grant, 2'b00);
    check("reset_strobes", {K1, K2, busy, done}, 4'b0000);
    Reset = 1'b1;

    // Contention after reset: requester 0 first, then round-robin to 1.
    @(negedge Clock); #1;
    req = 2'b11; run_len = 4'd3;
    wait_ev(0, 5, "t1_k1");
    check("t1_grant", g_start, 2'b01);
    wait_ev(2, 10, "t1_done");
    check("t1_run_cycles", last_run, 3);
    check("t1_k1_k2_gap", k2_t - k1_t, 4);
    wait_ev(0, 5, "t1_k1_second");
    req = 2'b00;
    check("t1_grant_rr", g_start, 2'b10);
    check("t1_period", k1_t - prev_k1_t, 7);
    wait_ev(2, 10, "t1_done_second");
    wait_ev(4, 5, "t1_idle");

    // Zero length behaves as one.
    req = 2'b01; run_len = 4'd0;
    wait_ev(0, 5, "t2_k1");
    req = 2'b00;
    check("t2_grant", g_start, 2'b01);
    wait_ev(2, 8, "t2_done");
    check("t2_run_cycles", last_run, 1);
    check("t2_k1_k2_gap", k2_t - k1_t, 2);
    wait_ev(4, 5, "t2_idle");

    // Abort on the second RUN cycle.
    req = 2'b01; run_len = 4'd5;
    wait_ev(0, 5, "t3_k1");
    req = 2'b00;
    wait_ev(3, 3, "t3_run");
    @(negedge Clock); #1;
    abort = 1'b1;
    @(negedge Clock); #1;
    abort = 1'b0;
    wait_ev(2, 5, "t3_done");
    check("t3_run_cycles", last_run, 2);
    check("t3_k1_k2_gap", k2_t - k1_t, 3);
    wait_ev(4, 5, "t3_idle");

    // Asynchronous reset in the middle of RUN.
    req = 2'b10; run_len = 4'd6;
    wait_ev(0, 5, "t4_k1");
    req = 2'b00;
    check("t4_grant", g_start, 2'b10);
    wait_ev(3, 3, "t4_run");
    @(posedge Clock); #2;
    k2_save = k2_n; done_save = done_n;
    Reset = 1'b0;
    #1;
    check("t4_async_state", state, S_IDLE);
    check("t4_async_outs", {grant, K1, K2, busy, done}, 6'b000000);
    @(posedge Clock); #2;
    Reset = 1'b1;
    repeat (12) @(negedge Clock);
    #1;
    check("t4_no_k2", k2_n - k2_save, 0);
    check("t4_no_done", done_n - done_save, 0);
    check("t4_idle_after", state, S_IDLE);

    // Single requester held: back-to-back cycles every 5 clocks.
    req = 2'b10; run_len = 4'd1;
    wait_ev(0, 5, "t5_k1_a");
    wait_ev(0, 8, "t5_k1_b");
    check("t5_period_a", k1_t - prev_k1_t, 5);
    check("t5_grant", g_start, 2'b10);
    wait_ev(0, 8, "t5_k1_c");
    req = 2'b00;
    check("t5_period_b", k1_t - prev_k1_t, 5);
    check("t5_grant_c", g_start, 2'b10);
    wait_ev(2, 6, "t5_done");
    wait_ev(4, 5, "t5_idle");

    // Maximum length with abort asserted only in IDLE, STOP and CLEAR.
    abort = 1'b1; req = 2'b01; run_len = 4'hF;
    wait_ev(0, 5, "t6_k1");
    abort = 1'b0; req = 2'b00;
    wait_ev(1, 20, "t6_k2");
    check("t6_k1_k2_gap", k2_t - k1_t, 16);
    abort = 1'b1;
    wait_ev(2, 5, "t6_done");
    check("t6_run_cycles", last_run, 15);
    wait_ev(4, 5, "t6_idle");
    repeat (3) @(negedge Clock);
    #1;
    check("t6_idle_abort", state, S_IDLE);
    abort = 1'b0;
    repeat (2) @(negedge Clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
